// File: rtl/timer_pkg.sv
// timer_pkg -- shared definitions for the timer_ctrl block.
//   TIMER_WIDTH_DEF     : default counter / period width
//   TIMER_PRE_WIDTH_DEF : default prescaler divide-value width
//   timer_state_e       : controller FSM state encoding
package timer_pkg;

  localparam int unsigned TIMER_WIDTH_DEF     = 16;
  localparam int unsigned TIMER_PRE_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/tc_prescaler.sv
// tc_prescaler -- free-running divider producing one tick every div+1
// enabled cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the divider this cycle (hold when low)
//   clr        : synchronous clear to 0, overrides en
//   div        : terminal divider value (0 = tick every enabled cycle)
//   tick       : high in the cycle whose rising edge completes a division
module tc_prescaler #(
  parameter int unsigned PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PRE_WIDTH-1:0] div,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] cnt_q;
  logic [PRE_WIDTH-1:0] cnt_d;

  // Tick is combinational so the controller can act on the same edge
  // that wraps the divider.
  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == div) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl -- programmable one-shot / periodic timer with prescaler.
//   clk, rst_n   : clock, asynchronous active-low reset
//   cfg_valid    : config offer, accepted when cfg_ready is also high
//   cfg_ready    : high in IDLE or DONE
//   cfg_period   : terminal count value
//   cfg_prescale : tick every cfg_prescale+1 cycles
//   cfg_periodic : 1 = auto-reload, 0 = one-shot
//   start/pause/stop : level commands, priority stop > pause > start
//   count        : current count (registered)
//   busy / done  : RUN-or-PAUSE / DONE status
//   irq          : registered one-cycle terminal-count pulse
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH     = TIMER_WIDTH_DEF,
  parameter int unsigned PRE_WIDTH = TIMER_PRE_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WIDTH-1:0]     cfg_period,
  input  logic [PRE_WIDTH-1:0] cfg_prescale,
  input  logic                 cfg_periodic,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic                 irq
);

  timer_state_e state_q, state_d;

  logic [WIDTH-1:0]     period_q;
  logic [PRE_WIDTH-1:0] prescale_q;
  logic                 periodic_q;
  logic [WIDTH-1:0]     count_q, count_d;
  logic                 irq_q, irq_d;

  // Commands after priority resolution.
  logic stop_cmd, pause_cmd, start_cmd;
  assign stop_cmd  = stop;
  assign pause_cmd = pause & ~stop;
  assign start_cmd = start & ~stop & ~pause;

  logic idle_or_done;
  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);

  logic cfg_fire;
  assign cfg_fire = cfg_valid & cfg_ready;

  // The divider only advances in RUN when no stop/pause is being taken,
  // so a tick coinciding with a pause edge is simply never generated.
  logic presc_en, presc_clr, tick, terminal;
  assign presc_en  = (state_q == ST_RUN) && !stop_cmd && !pause_cmd;
  assign presc_clr = stop_cmd || (start_cmd && idle_or_done);
  assign terminal  = tick && (count_q == period_q);

  tc_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .clr  (presc_clr),
    .div  (prescale_q),
    .tick (tick)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (stop_cmd) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_cmd) state_d = ST_RUN;
        ST_RUN: begin
          if (pause_cmd)                    state_d = ST_PAUSE;
          else if (terminal && !periodic_q) state_d = ST_DONE;
        end
        ST_PAUSE: if (start_cmd) state_d = ST_RUN;
        ST_DONE:  if (start_cmd) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE:  cfg_ready = 1'b1;
      ST_RUN:   busy      = 1'b1;
      ST_PAUSE: busy      = 1'b1;
      ST_DONE: begin
        cfg_ready = 1'b1;
        done      = 1'b1;
      end
      default:  cfg_ready = 1'b0;
    endcase
  end

  // Count / irq datapath
  always_comb begin
    count_d = count_q;
    irq_d   = 1'b0;
    if (stop_cmd) begin
      count_d = '0;
    end else if (start_cmd && idle_or_done) begin
      count_d = '0;
    end else if (tick) begin
      if (terminal) begin
        irq_d   = 1'b1;
        count_d = periodic_q ? '0 : count_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  // Config registers; a transfer never touches count or state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
    end else if (cfg_fire) begin
      period_q   <= cfg_period;
      prescale_q <= cfg_prescale;
      periodic_q <= cfg_periodic;
    end
  end

  assign count = count_q;
  assign irq   = irq_q;

endmodule
